alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand and result width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), giving the shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept an operation this cycle.
REQ-007 SHALL have port in1, input, XLEN, operand A.
REQ-008 SHALL have port in2, input, XLEN, operand B.
REQ-009 SHALL have port ALUop, input, 4, the operation select.
REQ-010 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-012 SHALL have port out, output, XLEN, the result.
REQ-013 SHALL have port zflag, output, 1, which is 1 exactly when out equals 0.
REQ-014 SHALL have port illegal, output, 1, meaning the accepted ALUop was not one of the listed encodings.

Function
REQ-015 SHALL decode ALUop as follows: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 1100 NOR; 0011 XOR; 0100 SLL; 0101 SRL; 1101 SRA; 1000 SLTU; 1001 MUL; 1010 DIVU; 1011 REMU.
REQ-016 SHALL accept an operation on a cycle where in_valid and in_ready are both 1, and SHALL latch in1, in2 and ALUop at that edge.
REQ-017 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-018 SHALL, on acceptance of a single-cycle operation (every op except MUL, DIVU and REMU), register the result and go to DONE, so that out_valid=1 on the next cycle (latency 1).
REQ-019 SHALL, on acceptance of MUL, DIVU or REMU, go to BUSY and iterate exactly XLEN cycles, then go to DONE, giving out_valid exactly XLEN+1 cycles after acceptance.
REQ-020 SHALL compute MUL by iterative shift-add and return the low XLEN bits of the product.
REQ-021 SHALL compute DIVU and REMU by unsigned restoring division, one quotient bit per cycle.
REQ-022 SHALL, when in2 is 0 for DIVU or REMU, return all-ones for DIVU and in1 for REMU, still taking the full XLEN+1 cycle latency.
REQ-023 SHALL take the shift amount for SLL, SRL and SRA from in2[SHW-1:0] only; SRA shall replicate in1[XLEN-1].
REQ-024 SHALL implement all arithmetic as modulo 2^XLEN with wrap-around, and SHALL report no overflow.
REQ-025 SHALL return 1 for SLT/SLTU when the signed/unsigned comparison in1 < in2 is true, and 0 otherwise.
REQ-026 SHALL, for an undefined ALUop, complete in 1 cycle with out=0, zflag=1 and illegal=1; illegal shall be 0 for every defined op.
REQ-027 SHALL hold out, zflag and illegal stable in DONE while out_ready=0.
REQ-028 SHALL drive in_ready=1 in IDLE, and in DONE when out_ready=1, and 0 otherwise.
REQ-029 SHALL retire the result when out_valid=1 and out_ready=1; with no simultaneous acceptance it shall go to IDLE.
REQ-030 SHALL, when a result retires and a new operation is accepted in the same cycle, load the new operation with no bubble, sustaining 1 single-cycle op per cycle.
REQ-031 SHALL ignore in_valid while in BUSY, leaving its operands unlatched.

Reset
REQ-032 SHALL, while rst_n=0 and independent of clk, force state=IDLE, out_valid=0, out=0, zflag=1, illegal=0, and clear all iteration counters and datapath registers.
REQ-033 SHALL, on reset asserted mid-BUSY, abandon the operation and produce no out_valid after release.
REQ-034 SHALL, in the first clk edge after rst_n rises, already present in_ready=1.

Verification
REQ-035 SHALL be verified with SUB in1=5, in2=5 held for 1 cycle -> next cycle out_valid=1, out=0, zflag=1.
REQ-036 SHALL be verified with SLT in1=0xFFFF_FFFF_FFFF_FFFF, in2=1 -> out=1; SLTU with the same operands -> out=0.
REQ-037 SHALL be verified with MUL in1=0x1_0000_0001, in2=3 -> out_valid exactly 65 cycles later, out=0x3_0000_0003, in_ready=0 throughout BUSY.
REQ-038 SHALL be verified with DIVU 100/0 and REMU 100/0 -> outputs 0xFFFF_FFFF_FFFF_FFFF and 100 respectively; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-039 SHALL be verified with back-to-back ADD 1+2 and SRA 0x8000_0000_0000_0000 by 4 on consecutive cycles with out_ready=1 -> outputs 3 then 0xF800_0000_0000_0000 on consecutive cycles; then with out_ready=0 for 3 cycles -> out held.
REQ-040 SHALL be verified with rst_n pulsed low at cycle 10 of a DIVU -> out_valid=0, out=0, in_ready=1 after release, and no stale result.

Source files
------------

// File: rtl/alu_muldiv.sv
// Integer ALU with iterative multiply and restoring unsigned divide.
// One operation in flight; valid/ready handshake on both the operation and the result sides.
module alu_muldiv #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  logic [3:0]      ALUop,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out,
   output logic            zflag,
   output logic            illegal
);

   localparam logic [3:0] OpMul  = 4'b1001;
   localparam logic [3:0] OpDivu = 4'b1010;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   a_q, b_q, acc_q, res_q;
   logic [3:0]        op_q;
   logic [SHW-1:0]    cnt_q;
   logic              ill_q;

   logic [XLEN-1:0]   alu_res;
   logic              alu_ill, is_multi;
   logic [SHW-1:0]    shamt;
   logic              accept, last;
   logic [XLEN:0]     div_sh, div_diff;
   logic [XLEN-1:0]   rem_nx, quo_nx, mul_nx;

   assign shamt     = in2[SHW-1:0];
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt_q == SHW'(XLEN - 1));
   assign out       = res_q;
   assign zflag     = (res_q == '0);
   assign illegal   = ill_q;

   always_comb begin
      alu_res  = '0;
      alu_ill  = 1'b0;
      is_multi = 1'b0;
      case (ALUop)
         4'b0000: alu_res = in1 & in2;
         4'b0001: alu_res = in1 | in2;
         4'b0010: alu_res = in1 + in2;
         4'b0110: alu_res = in1 - in2;
         4'b0111: alu_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
         4'b1100: alu_res = ~(in1 | in2);
         4'b0011: alu_res = in1 ^ in2;
         4'b0100: alu_res = in1 << shamt;
         4'b0101: alu_res = in1 >> shamt;
         4'b1101: alu_res = $signed(in1) >>> shamt;
         4'b1000: alu_res = {{(XLEN-1){1'b0}}, in1 < in2};
         4'b1001, 4'b1010, 4'b1011: is_multi = 1'b1;
         default: alu_ill = 1'b1;
      endcase
   end

   // MUL: a_q multiplicand (shifts left), b_q multiplier (shifts right), acc_q product.
   // DIV: a_q divisor, b_q dividend shifting out / quotient shifting in, acc_q remainder.
   always_comb begin
      mul_nx   = b_q[0] ? acc_q + a_q : acc_q;
      div_sh   = {acc_q, b_q[XLEN-1]};
      div_diff = div_sh - {1'b0, a_q};
      if (!div_diff[XLEN]) begin
         rem_nx = div_diff[XLEN-1:0];
         quo_nx = {b_q[XLEN-2:0], 1'b1};
      end else begin
         rem_nx = div_sh[XLEN-1:0];
         quo_nx = {b_q[XLEN-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = is_multi ? BUSY : DONE;
         BUSY: if (last) state_d = DONE;
         DONE: begin
            if (accept) state_d = is_multi ? BUSY : DONE;
            else if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= ALUop;
            cnt_q <= '0;
            if (is_multi) begin
               a_q   <= (ALUop == OpMul) ? in1 : in2;
               b_q   <= (ALUop == OpMul) ? in2 : in1;
               acc_q <= '0;
            end else begin
               res_q <= alu_res;
               ill_q <= alu_ill;
            end
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            if (op_q == OpMul) begin
               acc_q <= mul_nx;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
            end else begin
               acc_q <= rem_nx;
               b_q   <= quo_nx;
            end
            if (last) begin
               res_q <= (op_q == OpMul) ? mul_nx : (op_q == OpDivu) ? quo_nx : rem_nx;
               ill_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed checks of alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XLEN-1:0] in1 = '0;
   logic [XLEN-1:0] in2 = '0;
   logic [3:0]      ALUop = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] out;
   logic            zflag;
   logic            illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_muldiv #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .ALUop     (ALUop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zflag     (zflag),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the operation table.
   task automatic ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] res, output logic ill, output int lat);
      ill = 1'b0;
      lat = 1;
      case (op)
         4'b0000: res = a & b;
         4'b0001: res = a | b;
         4'b0010: res = a + b;
         4'b0110: res = a - b;
         4'b0111: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'b1100: res = ~(a | b);
         4'b0011: res = a ^ b;
         4'b0100: res = a << b[5:0];
         4'b0101: res = a >> b[5:0];
         4'b1101: res = $signed(a) >>> b[5:0];
         4'b1000: res = (a < b) ? 64'd1 : 64'd0;
         4'b1001: begin res = a * b; lat = XLEN + 1; end
         4'b1010: begin res = (b == 0) ? '1 : a / b; lat = XLEN + 1; end
         4'b1011: begin res = (b == 0) ? a : a % b; lat = XLEN + 1; end
         default: begin res = '0; ill = 1'b1; end
      endcase
   endtask

   // Issue one op, wait for its result, hold it for `stall` cycles, then retire it.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int stall);
      logic [63:0] exp_res;
      logic        exp_ill;
      int          exp_lat, lat, waited;
      logic        rdy_in_busy;
      ref_model(op, a, b, exp_res, exp_ill, exp_lat);
      in_valid = 1'b1; ALUop = op; in1 = a; in2 = b; out_ready = 1'b0;
      waited = 0;
      while (!in_ready && waited < 200) begin
         @(posedge clk); #1; waited++;
      end
      check({tag, " accept"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      rdy_in_busy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_in_busy = 1'b1;
         @(posedge clk); #1; lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " in_ready busy"}, 64'(rdy_in_busy), 64'd0);
      check({tag, " out"}, out, exp_res);
      check({tag, " zflag"}, 64'(zflag), 64'(exp_res == 0));
      check({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         check({tag, " hold valid"}, 64'(out_valid), 64'd1);
         check({tag, " hold out"}, out, exp_res);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " retired"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [63:0] a, b;
      int          cnt;

      // Reset state, asserted before any clock edge.
      #2;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst out", out, 64'd0);
      check("rst zflag", 64'(zflag), 64'd1);
      check("rst illegal", 64'(illegal), 64'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-rst in_ready", 64'(in_ready), 64'd1);

      do_op("sub5-5", 4'b0110, 64'd5, 64'd5, 0);
      do_op("slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
      do_op("sltu", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
      do_op("mul", 4'b1001, 64'h1_0000_0001, 64'd3, 0);
      do_op("divu100/0", 4'b1010, 64'd100, 64'd0, 0);
      do_op("remu100/0", 4'b1011, 64'd100, 64'd0, 0);
      do_op("divu100/7", 4'b1010, 64'd100, 64'd7, 0);
      do_op("remu100/7", 4'b1011, 64'd100, 64'd7, 1);
      do_op("illegal1110", 4'b1110, 64'd9, 64'd3, 2);
      do_op("sll big amt", 4'b0100, 64'd1, 64'hFF00_0000_0000_0041, 0);

      // Back-to-back ADD then SRA with no bubble, then a 3-cycle stall.
      out_ready = 1'b1;
      in_valid = 1'b1; ALUop = 4'b0010; in1 = 64'd1; in2 = 64'd2;
      @(posedge clk); #1;
      ALUop = 4'b1101; in1 = 64'h8000_0000_0000_0000; in2 = 64'd4;
      check("b2b add valid", 64'(out_valid), 64'd1);
      check("b2b add out", out, 64'd3);
      check("b2b add in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b sra valid", 64'(out_valid), 64'd1);
      check("b2b sra out", out, 64'hF800_0000_0000_0000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("b2b hold valid", 64'(out_valid), 64'd1);
         check("b2b hold out", out, 64'hF800_0000_0000_0000);
         check("b2b hold in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("b2b retired", 64'(out_valid), 64'd0);

      // Reset during a divide abandons it.
      in_valid = 1'b1; ALUop = 4'b1010; in1 = 64'd12345; in2 = 64'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 64'(out_valid), 64'd0);
      check("midrst out", out, 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst in_ready", 64'(in_ready), 64'd1);
      cnt = 0;
      for (int k = 0; k < 80; k++) begin
         if (out_valid) cnt++;
         @(posedge clk); #1;
      end
      check("midrst no stale valid", 64'(cnt), 64'd0);
      check("midrst out after", out, 64'd0);

      // Random operations with random result stalls.
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 20));
         if ($urandom_range(0, 7) == 0) a = b;
         do_op("rand", op, a, b, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
